// File: rtl/branch_predictor.sv
// Direct-mapped 2-bit counter branch predictor with target store and EX-driven redirect.
// Optional tag storage and compare: define BP_TAG_CHECK_EN.
module branch_predictor #(
  parameter int ENTRIES = 64
) (
  input  logic        clk,
  input  logic        rst,
  output logic        init_done,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic        upd_is_b_type,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_target,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  localparam int IDX_W = $clog2(ENTRIES);

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_e;

  state_e             state_q;
  state_e             state_d;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   idx_d;
  logic               init_done_q;
  logic               redirect_valid_q;
  logic               redirect_valid_d;
  logic [31:0]        redirect_pc_q;
  logic [31:0]        redirect_pc_d;

  logic [ENTRIES-1:0] valid_q;
  logic [1:0]         ctr_q [ENTRIES];
  logic [31:0]        tgt_q [ENTRIES];

  logic               run;
  logic               init_we;

  logic [IDX_W-1:0]   l_idx;
  logic               l_hit;
  logic [IDX_W-1:0]   u_idx;
  logic               u_hit;
  logic               trn;
  logic               mis;
  logic               wr_en;
  logic [1:0]         ctr_old;
  logic [1:0]         ctr_d;
  logic [31:0]        tgt_d;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic: one table entry cleared per INIT cycle
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (rst) begin
      state_d = S_INIT;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        S_INIT: begin
          idx_d = idx_q + 1'b1;
          if (idx_q == IDX_W'(ENTRIES - 1)) begin
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          state_d = S_RUN;
        end
      endcase
    end
  end

  // Output decode
  always_comb begin
    run     = 1'b0;
    init_we = 1'b0;
    if (!rst) begin
      unique case (state_q)
        S_INIT:  init_we = 1'b1;
        S_RUN:   run     = 1'b1;
      endcase
    end
  end

  assign l_idx = if_pc[IDX_W+1:2];
  assign u_idx = upd_pc[IDX_W+1:2];

`ifdef BP_TAG_CHECK_EN
  localparam int TAG_W = 32 - IDX_W - 2;
  logic [TAG_W-1:0]   tag_q [ENTRIES];

  assign l_hit = valid_q[l_idx]
               && (tag_q[l_idx] == if_pc[31:IDX_W+2]);
  assign u_hit = valid_q[u_idx]
               && (tag_q[u_idx] == upd_pc[31:IDX_W+2]);
`else
  assign l_hit = valid_q[l_idx];
  assign u_hit = valid_q[u_idx];
`endif

  // Lookup reads pre-update contents; no bypass from training
  always_comb begin
    pred_taken  = 1'b0;
    pred_target = '0;
    if (run) begin
      pred_taken  = l_hit & ctr_q[l_idx][1];
      pred_target = l_hit ? tgt_q[l_idx] : if_pc + 32'd4;
    end
  end

  assign trn = run & upd_valid & upd_is_b_type;
  assign mis = (upd_taken != upd_pred_taken)
             | (upd_taken & (upd_target != upd_pred_target));

  always_comb begin
    ctr_old = ctr_q[u_idx];
    ctr_d   = 2'b10;
    tgt_d   = upd_target;
    wr_en   = trn & (u_hit | upd_taken);
    if (u_hit) begin
      if (upd_taken) begin
        ctr_d = (ctr_old == 2'b11) ? 2'b11 : ctr_old + 2'd1;
      end else begin
        ctr_d = (ctr_old == 2'b00) ? 2'b00 : ctr_old - 2'd1;
        tgt_d = tgt_q[u_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (init_we) begin
      valid_q[idx_q] <= 1'b0;
      ctr_q[idx_q]   <= 2'b01;
    end else if (wr_en) begin
      valid_q[u_idx] <= 1'b1;
      ctr_q[u_idx]   <= ctr_d;
      tgt_q[u_idx]   <= tgt_d;
`ifdef BP_TAG_CHECK_EN
      tag_q[u_idx]   <= upd_pc[31:IDX_W+2];
`endif
    end
  end

  always_comb begin
    redirect_valid_d = trn & mis;
    redirect_pc_d    = redirect_pc_q;
    if (redirect_valid_d) begin
      redirect_pc_d = upd_taken ? upd_target : upd_pc + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      init_done_q      <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      init_done_q      <= (state_d == S_RUN);
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  assign init_done      = init_done_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: redirects queued at drive time.
module tb_branch_predictor;

  localparam int ENTRIES = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_done;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic        upd_is_b_type;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  always #5 clk = ~clk;

  branch_predictor #(.ENTRIES(ENTRIES)) dut (
    .clk             (clk),
    .rst             (rst),
    .init_done       (init_done),
    .if_pc           (if_pc),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .upd_valid       (upd_valid),
    .upd_is_b_type   (upd_is_b_type),
    .upd_pc          (upd_pc),
    .upd_taken       (upd_taken),
    .upd_target      (upd_target),
    .upd_pred_taken  (upd_pred_taken),
    .upd_pred_target (upd_pred_target),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc)
  );

  typedef struct {
    logic        v;
    logic [31:0] pc;
  } redir_t;

  redir_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_upd(input logic v, input logic b,
                           input logic [31:0] pc, input logic tk,
                           input logic [31:0] tgt, input logic ptk,
                           input logic [31:0] ptgt);
    redir_t e;
    upd_valid       = v;
    upd_is_b_type   = b;
    upd_pc          = pc;
    upd_taken       = tk;
    upd_target      = tgt;
    upd_pred_taken  = ptk;
    upd_pred_target = ptgt;
    e.v  = v & b & ((tk != ptk) | (tk & (tgt != ptgt)));
    e.pc = tk ? tgt : pc + 32'd4;
    exp_q.push_back(e);
  endtask

  task automatic finish_upd;
    redir_t e;
    tick();
    upd_valid     = 1'b0;
    upd_is_b_type = 1'b0;
    if (exp_q.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("redir_v", {31'd0, redirect_valid}, {31'd0, e.v});
      if (e.v) chk("redir_pc", redirect_pc, e.pc);
    end
  endtask

  task automatic upd(input logic v, input logic b,
                     input logic [31:0] pc, input logic tk,
                     input logic [31:0] tgt, input logic ptk,
                     input logic [31:0] ptgt);
    drive_upd(v, b, pc, tk, tgt, ptk, ptgt);
    finish_upd();
  endtask

  task automatic look(input string tag, input logic [31:0] pc,
                      input logic et, input logic [31:0] etgt);
    if_pc = pc;
    #1;
    chk({tag, "_tk"}, {31'd0, pred_taken}, {31'd0, et});
    chk({tag, "_tgt"}, pred_target, etgt);
  endtask

  // Counts cycles with init_done low after reset release, bounded
  task automatic sweep(input logic noisy);
    int cnt;
    cnt = 0;
    if (noisy) begin
      upd_valid       = 1'b1;
      upd_is_b_type   = 1'b1;
      upd_pc          = 32'h100;
      upd_taken       = 1'b1;
      upd_target      = 32'h300;
      upd_pred_taken  = 1'b0;
      upd_pred_target = 32'h104;
    end
    while (!init_done && cnt < 200) begin
      if_pc = $urandom;
      #1;
      chk("sweep_pred", {31'd0, pred_taken}, 32'd0);
      chk("sweep_redir", {31'd0, redirect_valid}, 32'd0);
      cnt++;
      @(posedge clk);
      #1;
    end
    upd_valid     = 1'b0;
    upd_is_b_type = 1'b0;
    chk("init_cycles", cnt, ENTRIES);
  endtask

  initial begin
    rst             = 1'b1;
    if_pc           = '0;
    upd_valid       = 1'b0;
    upd_is_b_type   = 1'b0;
    upd_pc          = '0;
    upd_taken       = 1'b0;
    upd_target      = '0;
    upd_pred_taken  = 1'b0;
    upd_pred_target = '0;

    tick();
    rst = 1'b0;
    repeat (20) tick();
    rst   = 1'b1;
    if_pc = 32'h100;
    tick();
    #1;
    chk("rst_init_done", {31'd0, init_done}, 32'd0);
    chk("rst_redir_v", {31'd0, redirect_valid}, 32'd0);
    chk("rst_redir_pc", redirect_pc, 32'd0);
    chk("rst_pred_tk", {31'd0, pred_taken}, 32'd0);
    chk("rst_pred_tgt", pred_target, 32'd0);
    rst = 1'b0;
    sweep(1'b1);
    chk("run_redir", {31'd0, redirect_valid}, 32'd0);
    look("cold", 32'h100, 1'b0, 32'h104);

    upd(1'b1, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
    upd(1'b0, 1'b0, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
    look("alloc", 32'h100, 1'b1, 32'h200);

    repeat (3) upd(1'b1, 1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
    upd(1'b1, 1'b1, 32'h100, 1'b0, 32'h200, 1'b1, 32'h200);
    look("sat_hi", 32'h100, 1'b1, 32'h200);
    upd(1'b1, 1'b1, 32'h100, 1'b0, 32'h200, 1'b1, 32'h200);
    look("weak_nt", 32'h100, 1'b0, 32'h200);

    drive_upd(1'b1, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h200);
    if_pc = 32'h100;
    #1;
    chk("same_old", {31'd0, pred_taken}, 32'd0);
    finish_upd();
    chk("same_new", {31'd0, pred_taken}, 32'd1);

`ifdef BP_TAG_CHECK_EN
    look("alias", 32'h100 + 4 * ENTRIES, 1'b0, 32'h204);
`else
    look("alias", 32'h100 + 4 * ENTRIES, 1'b1, 32'h200);
`endif

    upd(1'b1, 1'b1, 32'h100, 1'b1, 32'h300, 1'b1, 32'h200);
    look("retgt", 32'h100, 1'b1, 32'h300);
    upd(1'b0, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 32'h300);
    upd(1'b1, 1'b0, 32'h100, 1'b0, 32'h0, 1'b1, 32'h300);
    look("no_train", 32'h100, 1'b1, 32'h300);

    repeat (5) upd(1'b1, 1'b1, 32'h100, 1'b0, 32'h300, 1'b0, 32'h300);
    upd(1'b1, 1'b1, 32'h100, 1'b1, 32'h300, 1'b0, 32'h300);
    look("sat_lo", 32'h100, 1'b0, 32'h300);

    upd(1'b1, 1'b1, 32'h40, 1'b0, 32'h80, 1'b1, 32'h80);
    look("no_alloc", 32'h40, 1'b0, 32'h44);

    look("wrap_look", 32'hFFFF_FFFC, 1'b0, 32'h0);
    upd(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h10, 1'b1, 32'h10);

    rst = 1'b1;
    tick();
    chk("rerun_init", {31'd0, init_done}, 32'd0);
    rst = 1'b0;
    sweep(1'b0);
    look("rerun_cold", 32'h100, 1'b0, 32'h104);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side companion to the EX-stage branch condition evaluator. Predicts the branch direction and target for the IF PC.
- Receives resolved outcomes (is_b_type, branch_taken, target) back from EX, trains a direct-mapped table of 2-bit saturating counters plus targets, and issues a registered redirect on mispredict.
- Sits between the IF PC mux and the EX branch resolution path.

Parameters:
- ENTRIES, 64, number of table entries; power of two, minimum 4.
- IDX_W, $clog2(ENTRIES), index width; derived, not overridden.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- init_done  output  1  high once the table sweep is complete
- if_pc  input  32  PC being fetched
- pred_taken  output  1  prediction for if_pc (combinational)
- pred_target  output  32  predicted target for if_pc (combinational)
- upd_valid  input  1  EX stage holds a valid instruction this cycle
- upd_is_b_type  input  1  EX instruction is a conditional branch
- upd_pc  input  32  PC of the EX instruction
- upd_taken  input  1  resolved branch_taken from EX
- upd_target  input  32  resolved branch target from EX
- upd_pred_taken  input  1  prediction made for this instruction, piped from IF
- upd_pred_target  input  32  predicted target, piped from IF
- redirect_valid  output  1  mispredict; flush IF/ID and load redirect_pc
- redirect_pc  output  32  corrected fetch PC

Behaviour:
- Index = pc[IDX_W+1:2]. Each entry holds: valid, ctr[1:0], target[31:0], and tag[31:IDX_W+2] (the tag is stored only with the optional feature).
- Counter encoding: 00 strongly-not-taken, 01 weakly-not-taken, 10 weakly-taken, 11 strongly-taken.
- Reset and init:
  - rst=1 forces state INIT and idx_cnt=0.
  - Outputs under reset: init_done=0, redirect_valid=0, redirect_pc=0, pred_taken=0, pred_target=0.
  - INIT writes entry idx_cnt with valid=0 and ctr=01, one entry per cycle, for ENTRIES cycles, then moves to RUN. init_done is registered and goes high in the first RUN cycle.
  - In INIT: updates are ignored, pred_taken=0, redirect_valid=0.
  - rst asserted mid-sweep or in RUN restarts INIT from entry 0.
- Lookup (RUN only), combinational from if_pc:
  - hit = valid, plus tag match when the optional feature is compiled in.
  - pred_taken = hit & ctr[1].
  - pred_target = target when hit, else if_pc+4.
- Training (RUN; upd_valid & upd_is_b_type), registered, visible from the next cycle:
  - Hit & taken: ctr saturating increment (11 stays 11); target <= upd_target.
  - Hit & not taken: ctr saturating decrement (00 stays 00).
  - Miss & taken: allocate; valid=1, ctr=10, target=upd_target, tag written.
  - Miss & not taken: no write.
- Same-cycle lookup and update to the same index: lookup returns the pre-update contents. No bypass.
- Mispredict (RUN; upd_valid & upd_is_b_type) occurs when upd_taken != upd_pred_taken, or when upd_taken & (upd_target != upd_pred_target).
  - redirect_valid is registered: asserted for exactly one cycle, one cycle after the EX cycle.
  - redirect_pc = upd_taken ? upd_target : upd_pc+4.
- upd_valid=0 or upd_is_b_type=0: no training, redirect_valid=0 next cycle. Jumps are outside this block.
- All PC arithmetic is modulo 2^32; pc+4 wraps at 0xFFFFFFFC to 0x00000000.

Optional Feature:
- Macro BP_TAG_CHECK_EN.
- Defined: tag stored and compared on lookup and training. A taken update with a tag mismatch replaces the entry (ctr=10). A not-taken update with a mismatch leaves the entry unchanged.
- Undefined: no tag storage; hit = valid only, and aliasing PCs share entries.

Test Plan:
- rst high 1 cycle, then low -> init_done=0 for exactly ENTRIES (64) cycles, then 1. pred_taken=0 for every if_pc during the sweep.
- Taken branch at upd_pc=0x100, target 0x200, upd_pred_taken=0 -> redirect_valid=1 next cycle with redirect_pc=0x200. Next cycle if_pc=0x100 gives pred_taken=1, pred_target=0x200 (ctr=10).
- Three more taken updates at 0x100 -> ctr saturates at 11. Then one not-taken (pred_taken=1) -> redirect_pc=0x104, ctr=10, and a lookup still predicts taken.
- Correct prediction (upd_taken=1, pred_taken=1, targets equal 0x200) -> redirect_valid stays 0.
- Same-cycle update (taken) and lookup of 0x100 -> lookup shows the old value; the new value appears the following cycle.
- With BP_TAG_CHECK_EN, entry trained at 0x100, lookup at 0x100+4*ENTRIES (0x200) -> pred_taken=0, pred_target=0x204. Without the macro -> pred_taken=1.
